// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : matrix_scan_ctrl
// Brief   : Row-scan sequencer for a 16x16 LED matrix; optional PWM dimming
//           via `MATRIX_DIM_EN (adds the brightness input).
// Revision: 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl #(
    parameter int SCREENTIMERWIDTH = 10
) (
    input  logic        clk32mhz,
    input  logic        reset_n,
    input  logic        enable,
`ifdef MATRIX_DIM_EN
    input  logic [3:0]  brightness,
`endif
    output logic [3:0]  fb_row_addr,
    input  logic [15:0] fb_row_data,
    output logic        CSDI,
    output logic        CCLK,
    output logic        LE,
    output logic        RSDI,
    output logic        RCLK,
    output logic        OEB,
    output logic        frame_start,
    output logic        busy
);

    localparam int W = SCREENTIMERWIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_SHIFT   = 3'd2,
        S_LATCH   = 3'd3,
        S_ROWCLK  = 3'd4,
        S_DISPLAY = 3'd5
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_row;
    logic [4:0]   r_cnt;
    logic [W-1:0] r_dwell;
    logic [15:0]  r_shreg;
    logic         w_fetch_done;
    logic         w_shift_done;
    logic         w_dwell_done;
    logic         w_blank;

    assign w_fetch_done = (r_cnt == 5'd1);
    assign w_shift_done = (r_cnt == 5'd31);
    assign w_dwell_done = &r_dwell;
    assign fb_row_addr  = r_row;

`ifdef MATRIX_DIM_EN
    logic [3:0] r_bright;
    // Top four dwell bits form a 16-step PWM phase compared against brightness.
    assign w_blank = !(r_dwell[W-1 -: 4] < r_bright);
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk32mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        CSDI        = 1'b0;
        CCLK        = 1'b0;
        LE          = 1'b0;
        RSDI        = 1'b0;
        RCLK        = 1'b0;
        OEB         = 1'b1;
        frame_start = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (enable) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (w_fetch_done) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                // Bit is held across both halves; CCLK rises on odd cycles.
                CSDI = r_shreg[15];
                CCLK = r_cnt[0];
                if (w_shift_done) w_next = S_LATCH;
            end
            S_LATCH: begin
                LE     = 1'b1;
                RSDI   = (r_row == 4'd0);
                w_next = S_ROWCLK;
            end
            S_ROWCLK: begin
                RCLK   = 1'b1;
                RSDI   = (r_row == 4'd0);
                w_next = S_DISPLAY;
            end
            S_DISPLAY: begin
                OEB         = w_blank;
                frame_start = (r_dwell == '0) && (r_row == 4'd0);
                if (w_dwell_done) w_next = enable ? S_FETCH : S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk32mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_row   <= 4'd0;
            r_cnt   <= 5'd0;
            r_dwell <= '0;
            r_shreg <= 16'd0;
`ifdef MATRIX_DIM_EN
            r_bright <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_row <= 4'd0;
                    r_cnt <= 5'd0;
                end
                S_FETCH: begin
                    if (w_fetch_done) begin
                        r_shreg <= fb_row_data;
                        r_cnt   <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_SHIFT: begin
                    r_cnt <= w_shift_done ? 5'd0 : r_cnt + 5'd1;
                    if (r_cnt[0]) r_shreg <= {r_shreg[14:0], 1'b0};
                end
                S_ROWCLK: begin
                    r_dwell <= '0;
`ifdef MATRIX_DIM_EN
                    r_bright <= brightness;
`endif
                end
                S_DISPLAY: begin
                    if (w_dwell_done) begin
                        r_dwell <= '0;
                        r_row   <= enable ? r_row + 4'd1 : 4'd0;
                    end else begin
                        r_dwell <= r_dwell + W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// Scoreboard bench for matrix_scan_ctrl: stimulus queues expected column bits,
// row-clock events and blanking runs; a negedge monitor pops and compares them.
module tb_matrix_scan_ctrl;

    localparam int W          = 4;
    localparam int ROW_PERIOD = 36 + (1 << W);
    localparam int FRAME      = 16 * ROW_PERIOD;
`ifdef MATRIX_DIM_EN
    localparam int RUN = 4;
`else
    localparam int RUN = 16;
`endif

    logic        clk32mhz = 1'b0;
    logic        reset_n  = 1'b0;
    logic        enable   = 1'b0;
    logic [3:0]  fb_row_addr;
    logic [15:0] fb_row_data = 16'd0;
    logic        CSDI, CCLK, LE, RSDI, RCLK, OEB, frame_start, busy;
`ifdef MATRIX_DIM_EN
    logic [3:0]  brightness = 4'd4;
`endif

    logic [15:0] fb_mem [16] = '{16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF,
                                 16'h0000, 16'h1234, 16'h5A5A, 16'hC3A5,
                                 16'h00FF, 16'hFF00, 16'h0F0F, 16'hF0F0,
                                 16'h8421, 16'h7E81, 16'h3C3C, 16'h6996};

    int n_tests = 0;
    int n_fail  = 0;
    int q_col[$];
    int q_rclk[$];
    int q_run[$];

    matrix_scan_ctrl #(.SCREENTIMERWIDTH(W)) dut (
        .clk32mhz    (clk32mhz),
        .reset_n     (reset_n),
        .enable      (enable),
`ifdef MATRIX_DIM_EN
        .brightness  (brightness),
`endif
        .fb_row_addr (fb_row_addr),
        .fb_row_data (fb_row_data),
        .CSDI        (CSDI),
        .CCLK        (CCLK),
        .LE          (LE),
        .RSDI        (RSDI),
        .RCLK        (RCLK),
        .OEB         (OEB),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk32mhz = ~clk32mhz;

    // Framebuffer model: data appears one cycle after the address.
    always @(posedge clk32mhz) fb_row_data <= fb_mem[fb_row_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic extra(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT event with no expectation queued (t=%0t)", name, $time);
    endtask

    task automatic push_row(input int r, input bit full);
        for (int b = 15; b >= 0; b--) q_col.push_back(r * 2 + int'(fb_mem[r][b]));
        if (full) begin
            q_rclk.push_back(r * 2 + ((r == 0) ? 1 : 0));
            q_run.push_back(RUN);
        end
    endtask

    // Monitor
    logic p_cclk = 1'b0, p_rclk = 1'b0, p_le = 1'b0;
    int   le_cnt = 0, run = 0, cyc = 0, last_fs = -1;

    always @(negedge clk32mhz) begin
        int e;
        cyc++;
        if (CCLK && !p_cclk) begin
            if (q_col.size() == 0) extra("col_bit");
            else begin
                e = q_col.pop_front();
                chk("csdi", 32'(CSDI), 32'(e % 2));
                chk("col_row_addr", 32'(fb_row_addr), 32'(e / 2));
            end
        end
        if (LE && !p_le) le_cnt++;
        if (RCLK && !p_rclk) begin
            if (q_rclk.size() == 0) extra("rclk");
            else begin
                e = q_rclk.pop_front();
                chk("rsdi", 32'(RSDI), 32'(e % 2));
                chk("rclk_row_addr", 32'(fb_row_addr), 32'(e / 2));
                chk("le_pulses", 32'(le_cnt), 32'd1);
                chk("le_low_at_rclk", 32'(LE), 32'd0);
            end
            le_cnt = 0;
        end
        if (!OEB) run++;
        else if (run > 0) begin
            if (q_run.size() == 0) extra("oeb_run");
            else begin
                e = q_run.pop_front();
                chk("oeb_low_run", 32'(run), 32'(e));
            end
            run = 0;
        end
        if (!busy) last_fs = -1;
        if (frame_start) begin
            chk("fs_row", 32'(fb_row_addr), 32'd0);
            if (last_fs >= 0) chk("fs_period", 32'(cyc - last_fs), 32'(FRAME));
            last_fs = cyc;
        end
        p_cclk = CCLK;
        p_rclk = RCLK;
        p_le   = LE;
    end

    task automatic wait_shift_row(input int r, input int nth, input int limit);
        int hits = 0;
        bit was  = 1'b0;
        for (int i = 0; i < limit && hits < nth; i++) begin
            @(negedge clk32mhz);
            if (fb_row_addr == 4'(r) && CCLK) begin
                if (!was) hits++;
                was = 1'b1;
            end else if (fb_row_addr != 4'(r)) begin
                was = 1'b0;
            end
        end
        if (hits < nth) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_shift_row%0d: timeout, got %0d hits, expected %0d", r, hits, nth);
        end
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while (busy && i < limit) begin
            @(negedge clk32mhz);
            i++;
        end
        chk("reach_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge clk32mhz);
        chk("rst_oeb", 32'(OEB), 32'd1);
        chk("rst_csdi", 32'(CSDI), 32'd0);
        chk("rst_cclk", 32'(CCLK), 32'd0);
        chk("rst_le", 32'(LE), 32'd0);
        chk("rst_rsdi", 32'(RSDI), 32'd0);
        chk("rst_rclk", 32'(RCLK), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(fb_row_addr), 32'd0);

        // Two full frames plus rows 0..5 of a third.
        for (int p = 0; p < 2; p++)
            for (int r = 0; r < 16; r++) push_row(r, 1'b1);
        for (int r = 0; r <= 5; r++) push_row(r, 1'b1);

        reset_n = 1'b1;
        @(negedge clk32mhz);
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_addr", 32'(fb_row_addr), 32'd0);

        // A one-cycle enable glitch mid-row must be ignored.
        wait_shift_row(2, 1, 4 * ROW_PERIOD);
        enable = 1'b0;
        @(negedge clk32mhz);
        enable = 1'b1;

        wait_shift_row(5, 3, 3 * FRAME);
        enable = 1'b0;
        wait_idle(2 * ROW_PERIOD);
        @(negedge clk32mhz);
        chk("idle_addr", 32'(fb_row_addr), 32'd0);
        chk("idle_oeb", 32'(OEB), 32'd1);
        chk("q_col_drained", 32'(q_col.size()), 32'd0);
        chk("q_rclk_drained", 32'(q_rclk.size()), 32'd0);
        chk("q_run_drained", 32'(q_run.size()), 32'd0);
        repeat (5) @(negedge clk32mhz);
        chk("idle_stays", 32'(busy), 32'd0);

        // Restart from row 0, then reset asynchronously during row 2 shifting.
        push_row(0, 1'b1);
        push_row(1, 1'b1);
        push_row(2, 1'b0);
        enable = 1'b1;
        wait_shift_row(2, 1, 4 * ROW_PERIOD);
        #2 reset_n = 1'b0;
        #1;
        chk("async_cclk", 32'(CCLK), 32'd0);
        chk("async_oeb", 32'(OEB), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        q_col.delete();
        q_rclk.delete();
        q_run.delete();
        repeat (3) @(negedge clk32mhz);
        chk("rst_hold_le", 32'(LE), 32'd0);
        chk("rst_hold_rclk", 32'(RCLK), 32'd0);

        push_row(0, 1'b1);
        push_row(1, 1'b1);
        push_row(2, 1'b1);
        reset_n = 1'b1;
        wait_shift_row(2, 1, 4 * ROW_PERIOD);
        enable = 1'b0;
        wait_idle(2 * ROW_PERIOD);
        @(negedge clk32mhz);
        chk("q_col_final", 32'(q_col.size()), 32'd0);
        chk("q_rclk_final", 32'(q_rclk.size()), 32'd0);
        chk("q_run_final", 32'(q_run.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
